prbs7_checker: RTL and testbench

//  Self-synchronising PRBS7 (x^7+x^6+1) checker on the recovered-data side of the SERDES link.

---
 rtl/prbs7_checker.sv | 189 ++++++++++++++++++
 tb/tb_prbs7_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) bit-error checker with lock/loss-of-lock tracking.
// Define PRBS_CHK_BITCNT_EN to add the bit_cnt output (valid bits checked while LOCKED).
module prbs7_checker #(
  parameter int LOCK_CNT   = 32,
  parameter int WIN_LEN    = 128,
  parameter int UNLOCK_ERR = 8,
  parameter int ERR_CNT_W  = 16,
`ifdef PRBS_CHK_BITCNT_EN
  parameter int BIT_CNT_W  = 32,
`endif
  parameter int INVERT     = 0
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 din,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 sat,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [BIT_CNT_W-1:0] bit_cnt,
`endif
  output logic [1:0]           dbg_state
);

  // en is a valid-only qualifier: a bit is consumed on every rising edge with en=1, there is no
  // backpressure, and en=0 holds every register except err, which drops to 0.
  typedef enum logic [1:0] {SEED = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(UNLOCK_ERR + 1);

  state_t                 state_q, state_d;
  logic [6:0]             hist_q, hist_d;
  logic [6:0]             lfsr_q, lfsr_d;
  logic [2:0]             seed_cnt_q, seed_cnt_d;
  logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
  logic [WC_W-1:0]        win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]        win_err_q, win_err_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   sat_q, sat_d;
  logic                   locked_q, locked_d;
`ifdef PRBS_CHK_BITCNT_EN
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
`endif

  logic            d;
  logic            p_search;
  logic            p_lock;
  logic            match;
  logic            e_lock;
  logic [WE_W-1:0] win_err_inc;

  assign d           = din ^ (INVERT != 0);
  assign p_search    = hist_q[6] ^ hist_q[5];
  assign p_lock      = lfsr_q[6] ^ lfsr_q[5];
  // An all-zero history followed by another zero is the LFSR lock-up state, never a match.
  assign match       = (d == p_search) && !((hist_q == 7'd0) && !d);
  assign e_lock      = d ^ p_lock;
  assign win_err_inc = win_err_q + WE_W'(e_lock);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    sat_d       = sat_q;
`ifdef PRBS_CHK_BITCNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif
    if (en) begin
      case (state_q)
        SEED: begin
          hist_d = {hist_q[5:0], d};
          if (seed_cnt_q == 3'd6) begin
            state_d     = SEARCH;
            seed_cnt_d  = 3'd0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        SEARCH: begin
          hist_d = {hist_q[5:0], d};
          if (match) begin
            if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              lfsr_d      = {hist_q[5:0], d};
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MC_W'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Reference free-runs from its own taps so one bad bit yields exactly one error.
          lfsr_d = {lfsr_q[5:0], p_lock};
          err_d  = e_lock;
          if (e_lock && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (&err_cnt_d) sat_d = 1'b1;
          end
`ifdef PRBS_CHK_BITCNT_EN
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`endif
          if (win_err_inc >= WE_W'(UNLOCK_ERR)) begin
            state_d    = SEED;
            hist_d     = 7'd0;
            seed_cnt_d = 3'd0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WC_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WC_W'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clr) begin
      err_cnt_d = '0;
      sat_d     = 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_d = '0;
`endif
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= SEED;
      hist_q      <= 7'd0;
      lfsr_q      <= 7'd0;
      seed_cnt_q  <= 3'd0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      sat_q       <= 1'b0;
      locked_q    <= 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      sat_q       <= sat_d;
      locked_q    <= locked_d;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;
`ifdef PRBS_CHK_BITCNT_EN
  assign bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: default, INVERT=1 and narrow-counter instances.
module tb_prbs7_checker;
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic en_a, din_a, clr_a, locked_a, err_a, sat_a;
  logic [15:0] err_cnt_a;
  logic [1:0] st_a;
  logic en_b, din_b, clr_b, locked_b, err_b, sat_b;
  logic [15:0] err_cnt_b;
  logic [1:0] st_b;
  logic en_c, din_c, clr_c, locked_c, err_c, sat_c;
  logic [3:0] err_cnt_c;
  logic [1:0] st_c;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt_a, bit_cnt_b, bit_cnt_c;
`endif

  prbs7_checker dut_a (
    .clk(clk), .rstb(rstb), .en(en_a), .din(din_a), .clr(clr_a),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a), .sat(sat_a),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt(bit_cnt_a),
`endif
    .dbg_state(st_a));

  prbs7_checker #(.INVERT(1)) dut_b (
    .clk(clk), .rstb(rstb), .en(en_b), .din(din_b), .clr(clr_b),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b), .sat(sat_b),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt(bit_cnt_b),
`endif
    .dbg_state(st_b));

  prbs7_checker #(.ERR_CNT_W(4), .UNLOCK_ERR(200)) dut_c (
    .clk(clk), .rstb(rstb), .en(en_c), .din(din_c), .clr(clr_c),
    .locked(locked_c), .err(err_c), .err_cnt(err_cnt_c), .sat(sat_c),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_cnt(bit_cnt_c),
`endif
    .dbg_state(st_c));

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] g;

  task automatic gen_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic b);
    en_a = 1'b1; din_a = b;
    tick();
    en_a = 1'b0;
  endtask

  task automatic send_c(input logic b);
    en_c = 1'b1; din_c = b;
    tick();
    en_c = 1'b0;
  endtask

  task automatic do_reset();
    en_a = 0; din_a = 0; clr_a = 0;
    en_b = 0; din_b = 0; clr_b = 0;
    en_c = 0; din_c = 0; clr_c = 0;
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    g = 7'h5A;
  endtask

  task automatic lock_a();
    logic b;
    for (int i = 0; i < 39; i++) begin gen_bit(b); send_a(b); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({locked_a, err_a, sat_a, err_cnt_a} !== 19'd0) begin n_errors++; $display("FAIL reset_a: outputs=%h expected 0", {locked_a, err_a, sat_a, err_cnt_a}); end
    n_checks++; if (st_a !== 2'd0) begin n_errors++; $display("FAIL reset_state: state=%0d expected 0", st_a); end
    n_checks++; if ({locked_c, err_c, sat_c, err_cnt_c} !== 7'd0) begin n_errors++; $display("FAIL reset_c: outputs=%h expected 0", {locked_c, err_c, sat_c, err_cnt_c}); end
  endtask

  task automatic test_lock();
    logic b;
    int early = 0, pulses = 0, drops = 0;
    do_reset();
    for (int i = 1; i <= 38; i++) begin
      gen_bit(b); send_a(b);
      if (locked_a) early++;
      if (i == 7) begin
        n_checks++; if (st_a !== 2'd1) begin n_errors++; $display("FAIL seed_to_search: state=%0d expected 1", st_a); end
      end
    end
    n_checks++; if (early !== 0) begin n_errors++; $display("FAIL lock_early: cycles_locked=%0d expected 0", early); end
    gen_bit(b); send_a(b);
    n_checks++; if (locked_a !== 1'b1) begin n_errors++; $display("FAIL lock_bit39: locked=%b expected 1", locked_a); end
    for (int i = 0; i < 10000; i++) begin
      gen_bit(b); send_a(b);
      if (err_a) pulses++;
      if (!locked_a) drops++;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL clean_pulses: pulses=%0d expected 0", pulses); end
    n_checks++; if (drops !== 0) begin n_errors++; $display("FAIL clean_drops: drops=%0d expected 0", drops); end
    n_checks++; if (err_cnt_a !== 16'd0) begin n_errors++; $display("FAIL clean_err_cnt: err_cnt=%0d expected 0", err_cnt_a); end
`ifdef PRBS_CHK_BITCNT_EN
    n_checks++; if (bit_cnt_a !== 32'd10000) begin n_errors++; $display("FAIL clean_bit_cnt: bit_cnt=%0d expected 10000", bit_cnt_a); end
`endif
  endtask

  task automatic test_single_error();
    logic b;
    int pulses = 0;
    gen_bit(b); send_a(~b);
    n_checks++; if (err_a !== 1'b1) begin n_errors++; $display("FAIL single_err_pulse: err=%b expected 1", err_a); end
    n_checks++; if (err_cnt_a !== 16'd1) begin n_errors++; $display("FAIL single_err_cnt: err_cnt=%0d expected 1", err_cnt_a); end
    n_checks++; if (locked_a !== 1'b1) begin n_errors++; $display("FAIL single_err_locked: locked=%b expected 1", locked_a); end
    gen_bit(b); send_a(b);
    n_checks++; if (err_a !== 1'b0) begin n_errors++; $display("FAIL single_err_width: err=%b expected 0", err_a); end
    for (int i = 0; i < 200; i++) begin gen_bit(b); send_a(b); if (err_a) pulses++; end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL no_multiplication: pulses=%0d expected 0", pulses); end
    n_checks++; if (err_cnt_a !== 16'd1) begin n_errors++; $display("FAIL single_err_hold: err_cnt=%0d expected 1", err_cnt_a); end
  endtask

  task automatic test_unlock();
    logic b;
    do_reset();
    lock_a();
    for (int k = 0; k <= 14; k++) begin
      gen_bit(b);
      send_a((k % 2 == 0) ? ~b : b);
      if (k == 12) begin
        n_checks++; if (locked_a !== 1'b1) begin n_errors++; $display("FAIL unlock_7th: locked=%b expected 1", locked_a); end
      end
    end
    n_checks++; if (locked_a !== 1'b0) begin n_errors++; $display("FAIL unlock_8th: locked=%b expected 0", locked_a); end
    n_checks++; if (err_cnt_a !== 16'd8) begin n_errors++; $display("FAIL unlock_err_cnt: err_cnt=%0d expected 8", err_cnt_a); end
    n_checks++; if (st_a !== 2'd0) begin n_errors++; $display("FAIL unlock_state: state=%0d expected 0", st_a); end
    for (int i = 0; i < 38; i++) begin gen_bit(b); send_a(b); end
    n_checks++; if (locked_a !== 1'b0) begin n_errors++; $display("FAIL relock_early: locked=%b expected 0", locked_a); end
    gen_bit(b); send_a(b);
    n_checks++; if (locked_a !== 1'b1) begin n_errors++; $display("FAIL relock_39: locked=%b expected 1", locked_a); end
    n_checks++; if (err_cnt_a !== 16'd8) begin n_errors++; $display("FAIL relock_err_cnt: err_cnt=%0d expected 8", err_cnt_a); end
  endtask

  task automatic test_window_wrap();
    logic b;
    do_reset();
    lock_a();
    for (int i = 0; i < 121; i++) begin gen_bit(b); send_a(b); end
    for (int i = 121; i < 128; i++) begin gen_bit(b); send_a(~b); end
    n_checks++; if (locked_a !== 1'b1 || err_cnt_a !== 16'd7) begin n_errors++; $display("FAIL window_end: locked=%b err_cnt=%0d expected 1/7", locked_a, err_cnt_a); end
    gen_bit(b); send_a(~b);
    n_checks++; if (locked_a !== 1'b1 || err_cnt_a !== 16'd8) begin n_errors++; $display("FAIL window_wrap: locked=%b err_cnt=%0d expected 1/8", locked_a, err_cnt_a); end
  endtask

  task automatic test_all_zero();
    int rose_a = 0, rose_b = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      en_a = 1; din_a = 0; en_b = 1; din_b = 1;
      tick();
      if (locked_a || err_a) rose_a++;
      if (locked_b || err_b) rose_b++;
    end
    en_a = 0; en_b = 0;
    n_checks++; if (rose_a !== 0 || err_cnt_a !== 16'd0) begin n_errors++; $display("FAIL zeros: active_cycles=%0d err_cnt=%0d expected 0/0", rose_a, err_cnt_a); end
    n_checks++; if (rose_b !== 0 || err_cnt_b !== 16'd0) begin n_errors++; $display("FAIL ones_inverted: active_cycles=%0d err_cnt=%0d expected 0/0", rose_b, err_cnt_b); end
  endtask

  task automatic test_invert();
    logic b;
    do_reset();
    for (int i = 1; i <= 39; i++) begin
      gen_bit(b); en_b = 1; din_b = ~b; tick();
      if (i == 38) begin
        n_checks++; if (locked_b !== 1'b0) begin n_errors++; $display("FAIL invert_early: locked=%b expected 0", locked_b); end
      end
    end
    en_b = 0;
    n_checks++; if (locked_b !== 1'b1) begin n_errors++; $display("FAIL invert_lock: locked=%b expected 1", locked_b); end
  endtask

  task automatic test_saturation();
    logic b;
    do_reset();
    for (int i = 0; i < 39; i++) begin gen_bit(b); send_c(b); end
    n_checks++; if (locked_c !== 1'b1) begin n_errors++; $display("FAIL sat_lock: locked=%b expected 1", locked_c); end
    for (int i = 1; i <= 20; i++) begin
      gen_bit(b); send_c(~b);
      if (i == 14) begin
        n_checks++; if (err_cnt_c !== 4'd14 || sat_c !== 1'b0) begin n_errors++; $display("FAIL sat_14: err_cnt=%0d sat=%b expected 14/0", err_cnt_c, sat_c); end
      end
      if (i == 15) begin
        n_checks++; if (err_cnt_c !== 4'd15 || sat_c !== 1'b1) begin n_errors++; $display("FAIL sat_15: err_cnt=%0d sat=%b expected 15/1", err_cnt_c, sat_c); end
      end
    end
    n_checks++; if (err_cnt_c !== 4'd15 || sat_c !== 1'b1 || locked_c !== 1'b1) begin n_errors++; $display("FAIL sat_hold: err_cnt=%0d sat=%b locked=%b expected 15/1/1", err_cnt_c, sat_c, locked_c); end
    gen_bit(b); clr_c = 1; send_c(~b); clr_c = 0;
    n_checks++; if (err_cnt_c !== 4'd0 || sat_c !== 1'b0 || err_c !== 1'b1) begin n_errors++; $display("FAIL clr_with_err: err_cnt=%0d sat=%b err=%b expected 0/0/1", err_cnt_c, sat_c, err_c); end
    gen_bit(b); send_c(~b);
    n_checks++; if (err_cnt_c !== 4'd1) begin n_errors++; $display("FAIL after_clr: err_cnt=%0d expected 1", err_cnt_c); end
  endtask

  task automatic test_en_gaps();
    logic b;
    int valid = 0, early = 0, pulses = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000 && valid < 39; cyc++) begin
      en_a = 1'($urandom_range(0, 1));
      if (en_a) begin gen_bit(b); din_a = b; valid++; end
      else din_a = 1'($urandom_range(0, 1));
      tick();
      if (valid < 39 && locked_a) early++;
    end
    en_a = 0;
    n_checks++; if (valid !== 39) begin n_errors++; $display("FAIL gaps_budget: valid=%0d expected 39", valid); end
    n_checks++; if (early !== 0 || locked_a !== 1'b1) begin n_errors++; $display("FAIL gaps_lock: early=%0d locked=%b expected 0/1", early, locked_a); end
    gen_bit(b); send_a(~b);
    n_checks++; if (err_a !== 1'b1) begin n_errors++; $display("FAIL gaps_err: err=%b expected 1", err_a); end
    for (int i = 0; i < 20; i++) begin
      din_a = 1'($urandom_range(0, 1)); tick();
      if (err_a) pulses++;
    end
    n_checks++; if (pulses !== 0 || err_cnt_a !== 16'd1 || st_a !== 2'd2) begin n_errors++; $display("FAIL gaps_frozen: pulses=%0d err_cnt=%0d state=%0d expected 0/1/2", pulses, err_cnt_a, st_a); end
`ifdef PRBS_CHK_BITCNT_EN
    n_checks++; if (bit_cnt_a !== 32'd1) begin n_errors++; $display("FAIL gaps_bit_cnt: bit_cnt=%0d expected 1", bit_cnt_a); end
`endif
    gen_bit(b); send_a(~b);
    #2 rstb = 1'b0;
    #1;
    n_checks++; if ({locked_a, err_a, sat_a, err_cnt_a} !== 19'd0 || st_a !== 2'd0) begin n_errors++; $display("FAIL async_reset: outputs=%h state=%0d expected 0/0", {locked_a, err_a, sat_a, err_cnt_a}, st_a); end
    #2 rstb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_window_wrap();
    test_all_zero();
    test_invert();
    test_saturation();
    test_en_gaps();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
